// File: rtl/lcd_timing_driver.sv
// rtl/lcd_timing_driver.sv - RGB-parallel LCD timing generator and pixel sink
// Optional backlight PWM enabled by defining LCD_BL_PWM_EN.
module lcd_timing_driver #(
  parameter int H_SYNC  = 41,
  parameter int H_BACK  = 2,
  parameter int H_DISP  = 480,
  parameter int H_FRONT = 2,
  parameter int V_SYNC  = 10,
  parameter int V_BACK  = 2,
  parameter int V_DISP  = 272,
  parameter int V_FRONT = 2
`ifdef LCD_BL_PWM_EN
  , parameter int BL_DUTY = 255
`endif
) (
  input  logic        lcd_pclk,
  input  logic        rst_n,
  input  logic [23:0] pixel_data,
  output logic [10:0] pixel_x,
  output logic [10:0] pixel_y,
  output logic [10:0] h_disp,
  output logic [10:0] v_disp,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_de,
  output logic [23:0] lcd_rgb,
  output logic        lcd_bl,
  output logic        frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int HA      = H_SYNC + H_BACK;
  localparam int VA      = V_SYNC + V_BACK;

  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic        h_wrap;
  logic        v_wrap;
  logic        hs_raw;
  logic        vs_raw;
  logic        req;
  logic        hs_d1;
  logic        vs_d1;
  logic        de_d1;

  assign h_wrap = (h_cnt == 11'(H_TOTAL - 1));
  assign v_wrap = (v_cnt == 11'(V_TOTAL - 1));

  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_wrap ? '0 : h_cnt + 11'd1;
      if (h_wrap) begin
        v_cnt <= v_wrap ? '0 : v_cnt + 11'd1;
      end
    end
  end

  assign hs_raw = (h_cnt >= 11'(H_SYNC));
  assign vs_raw = (v_cnt >= 11'(V_SYNC));
  assign req    = (h_cnt >= 11'(HA)) && (h_cnt < 11'(HA + H_DISP)) &&
                  (v_cnt >= 11'(VA)) && (v_cnt < 11'(VA + V_DISP));

  // Pixel request goes out a full cycle ahead of the source's registered data.
  assign pixel_x = req ? (h_cnt - 11'(HA)) : '0;
  assign pixel_y = req ? (v_cnt - 11'(VA)) : '0;
  assign h_disp  = 11'(H_DISP);
  assign v_disp  = 11'(V_DISP);

  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      hs_d1       <= 1'b1;
      vs_d1       <= 1'b1;
      de_d1       <= 1'b0;
      lcd_hs      <= 1'b1;
      lcd_vs      <= 1'b1;
      lcd_de      <= 1'b0;
      lcd_rgb     <= '0;
      frame_start <= 1'b0;
    end else begin
      hs_d1       <= hs_raw;
      vs_d1       <= vs_raw;
      de_d1       <= req;
      lcd_hs      <= hs_d1;
      lcd_vs      <= vs_d1;
      lcd_de      <= de_d1;
      lcd_rgb     <= de_d1 ? pixel_data : 24'h0;
      frame_start <= h_wrap && v_wrap;
    end
  end

`ifdef LCD_BL_PWM_EN
  logic [7:0] pwm_cnt;

  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      lcd_bl  <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      lcd_bl  <= ({1'b0, pwm_cnt} < 9'(BL_DUTY));
    end
  end
`else
  assign lcd_bl = 1'b1;
`endif

endmodule
